// File: rtl/router_out_arb_xbar.sv
`default_nettype none
// router_out_arb_xbar -- one NoC output port: wormhole-locked round-robin select with registered flit/valid.
// Rev 1.0
module router_out_arb_xbar #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_IN-1:0]            req_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
  input  logic                         ready_in,
  output logic [NUM_IN-1:0]            grant_out,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         validout,
  output logic [SEL_W-1:0]             sel_out,
  output logic                         busy
);

  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_LOCKED = 1'b1;
  localparam logic [2:0] c_TYPE_HDR  = 3'b001;
  localparam logic [2:0] c_TYPE_TAIL = 3'b100;

  logic [0:0]            r_state;
  logic [SEL_W-1:0]      r_owner;
  logic [SEL_W-1:0]      r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic [NUM_IN-1:0]     w_eligible;
  logic                  w_found;
  logic [SEL_W-1:0]      w_winner;
  logic [NUM_IN-1:0]     w_grant;
  logic                  w_gnt_any;
  logic [SEL_W-1:0]      w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_gnt_flit;
  logic                  w_gnt_tail;

  // (base + off) mod NUM_IN for off < NUM_IN, valid for non-power-of-two port counts
  function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) s = s - NUM_IN;
    return s[SEL_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_elig
      assign w_eligible[gi] = req_in[gi] &
        (data_in[gi*DATA_WIDTH + DATA_WIDTH - 1 -: 3] == c_TYPE_HDR);
    end
  endgenerate

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_found && w_eligible[f_wrap(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (r_state == c_ST_IDLE) begin
      if (ready_in && w_found) w_grant[w_winner] = 1'b1;
    end else begin
      if (ready_in && req_in[r_owner]) w_grant[r_owner] = 1'b1;
    end
  end

  assign w_gnt_any  = |w_grant;
  assign w_gnt_idx  = (r_state == c_ST_IDLE) ? w_winner : r_owner;
  assign w_gnt_flit = data_in[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_gnt_tail = (w_gnt_flit[DATA_WIDTH-1 -: 3] == c_TYPE_TAIL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_gnt_any;
      if (w_gnt_any) r_data <= w_gnt_flit;
      if (r_state == c_ST_IDLE) begin
        if (w_gnt_any) begin
          r_owner <= w_winner;
          r_state <= c_ST_LOCKED;
        end
      end else if (w_gnt_any && w_gnt_tail) begin
        // Any non-tail flit from the owner (even a stray header) keeps the lock
        r_state  <= c_ST_IDLE;
        r_rr_ptr <= f_wrap(r_owner, 1);
      end
    end
  end

  assign grant_out = reset ? w_grant : '0;
  assign dataout   = r_data;
  assign validout  = r_valid;
  assign sel_out   = r_owner;
  assign busy      = (r_state == c_ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_router_out_arb_xbar.sv
`default_nettype none
// tb_router_out_arb_xbar -- directed vectors; expected flits queued at grant time and checked by a monitor.
// Rev 1.0
module tb_router_out_arb_xbar;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] BDY = 3'b010;
  localparam logic [2:0] TL  = 3'b100;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_in;
  logic [N*DW-1:0] data_in;
  logic            ready_in;
  logic [N-1:0]    grant_out;
  logic [DW-1:0]   dataout;
  logic            validout;
  logic [2:0]      sel_out;
  logic            busy;

  router_out_arb_xbar #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .data_in  (data_in),
    .ready_in (ready_in),
    .grant_out(grant_out),
    .dataout  (dataout),
    .validout (validout),
    .sel_out  (sel_out),
    .busy     (busy)
  );

  typedef struct {
    int          due;
    logic [31:0] flit;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mk(input logic [2:0] t, input int p, input int s);
    return {t, 5'(p), 24'(s)};
  endfunction

  task automatic set_port(input int p, input logic [2:0] t, input int s, input logic r);
    data_in[p*DW +: DW] = mk(t, p, s);
    req_in[p] = r;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; checks the combinational grant, queues the expected flit, advances one cycle.
  task automatic step(input logic [N-1:0] exp_g, input string nm);
    exp_t e;
    #2;
    chk(nm, 32'(grant_out), 32'(exp_g));
    for (int i = 0; i < N; i++) begin
      if (exp_g[i]) begin
        e.due  = cyc + 1;
        e.flit = data_in[i*DW +: DW];
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (validout) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got data 0x%0h want no output (cycle %0d)", dataout, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.due != cyc || dataout !== e.flit) begin
            bad++;
            $display("FAIL out_flit: got 0x%0h at cycle %0d want 0x%0h at cycle %0d",
                     dataout, cyc, e.flit, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid: got validout=0 at cycle %0d want 0x%0h", cyc, q[0].flit);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int order [6];
    int seq   [N];
    logic [N-1:0] g;
    order = '{0, 1, 4, 0, 1, 4};
    reset = 1'b1; req_in = '0; data_in = '0; ready_in = 1'b1;
    #1 reset = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, HDR, 0, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_grant", 32'(grant_out), 0);
    chk("rst_valid", 32'(validout), 0);
    chk("rst_data",  dataout, 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_sel",   32'(sel_out), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    step(5'b00001, "first_grant_p0");
    chk("busy_after_hdr", 32'(busy), 1);
    req_in = '0; set_port(0, TL, 1, 1'b1);
    step(5'b00001, "p0_tail");
    req_in = '0;
    step(5'b00000, "idle");

    set_port(2, HDR, 10, 1'b1); step(5'b00100, "p2_hdr");
    chk("p2_busy", 32'(busy), 1);
    chk("p2_sel", 32'(sel_out), 2);
    set_port(2, BDY, 11, 1'b1); step(5'b00100, "p2_body1");
    set_port(2, BDY, 12, 1'b1); step(5'b00100, "p2_body2");
    set_port(2, TL,  13, 1'b1); step(5'b00100, "p2_tail");
    chk("p2_busy_after_tail", 32'(busy), 0);
    req_in = '0;
    set_port(0, HDR, 20, 1'b1); set_port(1, HDR, 20, 1'b1);
    set_port(3, HDR, 20, 1'b1); set_port(4, HDR, 20, 1'b1);
    step(5'b01000, "rr3_picks_p3");
    set_port(3, TL, 21, 1'b1); step(5'b01000, "p3_tail_locked");

    req_in = '0;
    set_port(4, BDY, 30, 1'b1); set_port(0, HDR, 31, 1'b1);
    step(5'b00001, "wrap_p0");
    set_port(0, TL, 32, 1'b1); step(5'b00001, "wrap_p0_tail");
    req_in[0] = 1'b0;
    step(5'b00000, "body_in_idle_a");
    step(5'b00000, "body_in_idle_b");
    set_port(4, HDR, 40, 1'b1); step(5'b10000, "p4_hdr");
    set_port(4, TL,  41, 1'b1); step(5'b10000, "p4_tail");

    req_in = '0;
    for (int p = 0; p < N; p++) seq[p] = 50;
    set_port(0, HDR, 50, 1'b1); set_port(1, HDR, 50, 1'b1); set_port(4, HDR, 50, 1'b1);
    for (int k = 0; k < 6; k++) begin
      g = N'(1 << order[k]);
      step(g, "fair_hdr");
      seq[order[k]]++;
      set_port(order[k], TL, seq[order[k]], 1'b1);
      step(g, "fair_tail");
      seq[order[k]]++;
      set_port(order[k], HDR, seq[order[k]], 1'b1);
    end

    req_in = '0;
    set_port(1, HDR, 60, 1'b1); step(5'b00010, "p1_hdr");
    set_port(1, BDY, 61, 1'b1); set_port(3, HDR, 70, 1'b1);
    step(5'b00010, "p1_body_p3_waits");
    set_port(1, BDY, 62, 1'b1);
    ready_in = 1'b0;
    step(5'b00000, "backpressure_a");
    chk("bp_busy", 32'(busy), 1);
    step(5'b00000, "backpressure_b");
    ready_in = 1'b1;
    step(5'b00010, "p1_body2");
    set_port(1, TL, 63, 1'b1); step(5'b00010, "p1_tail");
    req_in[1] = 1'b0;
    step(5'b01000, "p3_after_p1");
    set_port(3, TL, 71, 1'b1); step(5'b01000, "p3_tail");

    req_in = '0;
    set_port(2, HDR, 80, 1'b1); step(5'b00100, "p2_lock");
    req_in[2] = 1'b0; set_port(0, HDR, 90, 1'b1);
    step(5'b00000, "drop_a");
    step(5'b00000, "drop_b");
    step(5'b00000, "drop_c");
    chk("drop_busy", 32'(busy), 1);
    set_port(2, HDR, 81, 1'b1); step(5'b00100, "hdr_as_body");
    set_port(2, TL,  82, 1'b1); step(5'b00100, "p2_tail_after_drop");
    req_in[2] = 1'b0;
    step(5'b00001, "p0_after_drop");
    set_port(0, TL, 91, 1'b1); step(5'b00001, "p0_tail2");

    req_in = '0;
    set_port(2, HDR, 100, 1'b1); step(5'b00100, "mid_hdr");
    set_port(2, BDY, 101, 1'b1); step(5'b00100, "mid_body");
    req_in = '0;
    step(5'b00000, "pre_reset");
    chk("pre_reset_busy", 32'(busy), 1);
    set_port(2, BDY, 102, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_data",  dataout, 0);
    chk("rstmid_valid", 32'(validout), 0);
    chk("rstmid_busy",  32'(busy), 0);
    chk("rstmid_sel",   32'(sel_out), 0);
    chk("rstmid_grant", 32'(grant_out), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(5'b00000, "body_after_reset_a");
    step(5'b00000, "body_after_reset_b");
    set_port(2, HDR, 103, 1'b1); step(5'b00100, "hdr_after_reset");
    set_port(2, TL,  104, 1'b1); step(5'b00100, "tail_after_reset");
    req_in = '0;
    step(5'b00000, "drain_a");
    step(5'b00000, "drain_b");
    chk("queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_out_arb_xbar.md
# router_out_arb_xbar

Parametrised output-port slice for the NoC router: one instance per output port, selecting among `NUM_IN` input-FIFO heads with a wormhole-locked round-robin arbiter and driving a registered flit plus write-valid to the downstream link. It replaces the purely combinational select-driven crossbar mux by folding arbitration, packet locking and an output register into one block. Input FIFOs sit upstream; the neighbour's (or local) input FIFO sits downstream.

## Interface
- `NUM_IN`, 5, number of candidate input ports (2..8); bit i corresponds to input port i.
- `DATA_WIDTH`, 32, flit width; flit type in `[DATA_WIDTH-1 -: 3]`: 3'b001 header, 3'b010 body, 3'b100 tail.
- `SEL_W`, `$clog2(NUM_IN)`, derived; width of `sel_out`.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_in`  in  NUM_IN  bit i: input FIFO i non-empty and its head flit is routed to this output.
- `data_in`  in  NUM_IN*DATA_WIDTH  head flit of FIFO i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ready_in`  in  1  downstream FIFO can accept a flit written at the next edge (not full).
- `grant_out`  out  NUM_IN  combinational one-hot pop strobe to FIFO i; at most one bit high.
- `dataout`  out  DATA_WIDTH  registered flit.
- `validout`  out  1  registered write strobe to downstream, high one cycle per flit.
- `sel_out`  out  SEL_W  registered index of current/last owner.
- `busy`  out  1  registered; high while in LOCKED.

## Operation
- States: IDLE, LOCKED. Registers: `state`, `owner` (SEL_W), `rr_ptr` (SEL_W), `dataout`, `validout`.
- IDLE: eligible[i] = req_in[i] & (type(data_in[i]) == header). If `ready_in` and any eligible: winner = first eligible index searching rr_ptr, rr_ptr+1, …, NUM_IN-1, 0, … (wrap mod NUM_IN). grant_out[winner]=1; next edge: dataout←flit, validout←1, owner←winner, sel_out←winner, state←LOCKED.
- IDLE with a requester whose head is body/tail: not eligible, not granted, stays pending (protocol violation; no drop).
- LOCKED: grant_out[owner] = req_in[owner] & ready_in; all other grants 0 regardless of requests. On grant: flit loaded, validout←1. If the granted flit is tail: state←IDLE, rr_ptr←(owner+1) mod NUM_IN.
- LOCKED, header from owner: forwarded as body; lock held until tail.
- No grant in a cycle: validout←0, dataout holds last value.
- Owner's req drops mid-packet: lock held, bubbles (validout=0) until it resumes.

## Timing
- Reset (async assert, sync deassertion handled upstream): state=IDLE, rr_ptr=0, owner=0, sel_out=0, dataout=0, validout=0, busy=0; grant_out=0 while reset low. Reset mid-packet abandons the packet.
- Latency: grant in cycle t → dataout/validout at t+1.
- Back-to-back: tail granted at t, new header may be granted at t+1 (no bubble between packets).
- `ready_in` low: grant_out=0 that cycle; state, owner and rr_ptr unchanged.
- `rr_ptr` updates only on tail transfer; never on header.
- Throughput: one flit/cycle while owner requests and ready_in high.

## Test plan
- Reset: hold reset low with all req_in=1 → grant_out=0, validout=0, dataout=0, busy=0; release → first grant to port 0.
- Single packet: NUM_IN=5, port 2 sends header/body/body/tail, ready_in=1 → grant_out=5'b00100 for 4 cycles, validout high cycles t+1..t+4, dataout matches flits in order, busy falls after tail, rr_ptr=3.
- Round-robin fairness: ports 0,1,4 each have continuous 2-flit packets → packet order 0,1,4,0,1,4, no bubbles between packets.
- Lock and backpressure: port 1 owns; port 3 raises header mid-packet, ready_in low 2 cycles → no grants, validout=0 those cycles, port 3 granted only after port 1 tail.
- Protocol/boundary: port 4 presents body flit in IDLE → never granted; owner req drops 3 cycles mid-packet → 3 bubbles, lock held; wrap: rr_ptr=4, only port 0 eligible → port 0 granted.
- Reset mid-packet: assert reset after header+body of port 2 → outputs reset immediately; after release port 2 body flit is ignored until a header.
